// File: rtl/conv_weight_streamer_3x3.sv
// Streams every 3x3 kernel weight of one conv layer from a 1-cycle-latency weight
// memory, one word per cycle, in output-channel / input-channel / row / column order.
`timescale 1ns/1ps
module conv_weight_streamer_3x3 #(
    parameter int DATA_WIDTH      = 32,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int KERNEL          = 3,
    parameter int ADDR_WIDTH      = 20,
    parameter int BASE_ADDR       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  valid_weight_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  last_ch_out,
    output logic                  busy,
    output logic                  done
);
    localparam int KK  = KERNEL * KERNEL;
    localparam int KW  = $clog2(KK + 1);
    localparam int CIW = $clog2(CHANNEL_NUM_IN + 1);
    localparam int COW = $clog2(CHANNEL_NUM_OUT + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [KW-1:0]         k_cnt_reg;
    logic [CIW-1:0]        ci_cnt_reg;
    logic [COW-1:0]        co_cnt_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;

    logic rd_valid_reg, rd_last_ch_reg, rd_last_layer_reg;
    logic valid_reg, last_ch_reg, done_reg;
    logic [DATA_WIDTH-1:0] weight_reg;

    logic issue, last_k, last_ci, last_co, last_ch_issue, last_layer_issue;

    assign last_k           = (k_cnt_reg == KW'(KK - 1));
    assign last_ci          = (ci_cnt_reg == CIW'(CHANNEL_NUM_IN - 1));
    assign last_co          = (co_cnt_reg == COW'(CHANNEL_NUM_OUT - 1));
    assign last_ch_issue    = last_k && last_ci;
    assign last_layer_issue = last_ch_issue && last_co;
    assign issue            = (state_reg == READ) && !hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN leaves once the layer's final weight is sitting in the output register.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = READ;
            READ:    if (issue && last_layer_issue) state_next = DRAIN;
            DRAIN:   if (done_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_cnt_reg  <= '0;
            ci_cnt_reg <= '0;
            co_cnt_reg <= '0;
            addr_reg   <= ADDR_WIDTH'(BASE_ADDR);
        end else if (state_reg == IDLE && start) begin
            k_cnt_reg  <= '0;
            ci_cnt_reg <= '0;
            co_cnt_reg <= '0;
            addr_reg   <= ADDR_WIDTH'(BASE_ADDR);
        end else if (issue) begin
            addr_reg <= addr_reg + ADDR_WIDTH'(1);
            if (last_k) begin
                k_cnt_reg <= '0;
                if (last_ci) begin
                    ci_cnt_reg <= '0;
                    if (!last_co) co_cnt_reg <= co_cnt_reg + COW'(1);
                end else begin
                    ci_cnt_reg <= ci_cnt_reg + CIW'(1);
                end
            end else begin
                k_cnt_reg <= k_cnt_reg + KW'(1);
            end
        end
    end

    // Tags travel alongside each read so they line up with mem_data one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_reg      <= 1'b0;
            rd_last_ch_reg    <= 1'b0;
            rd_last_layer_reg <= 1'b0;
            valid_reg         <= 1'b0;
            weight_reg        <= '0;
            last_ch_reg       <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            rd_valid_reg      <= issue;
            rd_last_ch_reg    <= issue && last_ch_issue;
            rd_last_layer_reg <= issue && last_layer_issue;
            valid_reg         <= rd_valid_reg;
            last_ch_reg       <= rd_valid_reg && rd_last_ch_reg;
            done_reg          <= rd_valid_reg && rd_last_layer_reg;
            if (rd_valid_reg) weight_reg <= mem_data;
        end
    end

    assign mem_rd_en        = issue;
    assign mem_addr         = addr_reg;
    assign valid_weight_out = valid_reg;
    assign weight_out       = weight_reg;
    assign last_ch_out      = last_ch_reg;
    assign done             = done_reg;
    assign busy             = (state_reg != IDLE);
endmodule

// File: tb/tb_conv_weight_streamer_3x3.sv
// Randomized scoreboard bench for conv_weight_streamer_3x3 (CIN=2, COUT=2, K=3,
// BASE=0x100); the memory model returns data equal to its address.
`timescale 1ns/1ps
module tb_conv_weight_streamer_3x3;
    localparam int DW     = 32;
    localparam int CIN    = 2;
    localparam int COUT   = 2;
    localparam int K      = 3;
    localparam int AW     = 20;
    localparam int BASE   = 32'h100;
    localparam int PER_CH = CIN * K * K;
    localparam int N      = COUT * PER_CH;
    localparam int NONE   = 1 << 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic          valid_weight_out;
    logic [DW-1:0] weight_out;
    logic          last_ch_out;
    logic          busy;
    logic          done;

    conv_weight_streamer_3x3 #(
        .DATA_WIDTH(DW), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT),
        .KERNEL(K), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .valid_weight_out(valid_weight_out), .weight_out(weight_out),
        .last_ch_out(last_ch_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_rd_en) mem_data <= DW'(mem_addr);

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        bit            lc;
        bit            dn;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] issue_map[int];
    int            busy_lo = 1;
    int            busy_hi = 0;
    bit            mon_en = 1'b0;
    bit            mon_ev;
    bit            hv[256];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a weight is due and checks every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_ev = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("valid", valid_weight_out, mon_ev);
            if (mon_ev) begin
                if (valid_weight_out) begin
                    chk("weight", weight_out, sb[0].data);
                    chk("last_ch", last_ch_out, sb[0].lc);
                    chk("done", done, sb[0].dn);
                    $display("weight cyc=%0d data=%0h last_ch=%0b done=%0b",
                             cyc, weight_out, last_ch_out, done);
                end
                void'(sb.pop_front());
            end else begin
                chk("last_ch_idle", last_ch_out, 0);
                chk("done_idle", done, 0);
            end
            chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            if (issue_map.exists(cyc)) begin
                chk("rd_en", mem_rd_en, 1);
                chk("rd_addr", mem_addr, issue_map[cyc]);
            end else begin
                chk("rd_en_idle", mem_rd_en, 0);
            end
        end
    end

    // Reference: reads are issued in the non-hold cycles from cycle 1 on, and each
    // word appears two cycles after its read; a reset at cycle rst_k drops anything later.
    task automatic run_layer(input int restart_k, input int rst_k);
        int base, issued, last_v, end_k;
        @(posedge clk); #1;
        start = 1'b1;
        hold  = hv[0];
        base  = cyc;
        issued = 0;
        last_v = 0;
        for (int t = 1; issued < N && t <= rst_k && t < 250; t++) begin
            if (!hv[t]) begin
                issue_map[base + t] = AW'(BASE + issued);
                if (t + 2 <= rst_k) begin
                    sb.push_back('{base + t + 2, DW'(BASE + issued),
                                   (issued % PER_CH) == PER_CH - 1, issued == N - 1});
                    last_v = t + 2;
                end
                issued++;
            end
        end
        end_k   = (rst_k < NONE) ? rst_k : last_v;
        busy_lo = base + 1;
        busy_hi = base + end_k;
        $display("layer start cyc=%0d restart_k=%0d rst_k=%0d expected_last=%0d",
                 base, restart_k, rst_k, base + last_v);
        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            start = (k == restart_k);
            hold  = hv[k];
            reset = (k == rst_k);
        end
        start = 1'b0;
        if (rst_k < NONE) begin
            @(posedge clk); #1;
            reset = 1'b0;
            hold  = 1'b0;
            @(negedge clk);
            chk("rst_weight", weight_out, 0);
            chk("rst_addr", mem_addr, AW'(BASE));
        end
    endtask

    task automatic clear_hv();
        foreach (hv[i]) hv[i] = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", mem_rd_en, 0);
        chk("reset_addr", mem_addr, AW'(BASE));
        chk("reset_valid", valid_weight_out, 0);
        chk("reset_weight", weight_out, 0);
        chk("reset_last_ch", last_ch_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        clear_hv();
        run_layer(-1, NONE);
        for (int i = 10; i < 14; i++) hv[i] = 1'b1;
        run_layer(-1, NONE);
        clear_hv();
        run_layer(20, NONE);
        run_layer(-1, 15);
        run_layer(-1, NONE);

        @(posedge clk); #1;
        start = 1'b1;
        reset = 1'b1;
        $display("start and reset together cyc=%0d", cyc);
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        repeat (5) @(posedge clk);

        clear_hv();
        for (int i = 0; i <= int'($urandom_range(8, 3)); i++) hv[i] = 1'b1;
        run_layer(-1, NONE);

        for (int r = 0; r < 4; r++) begin
            clear_hv();
            for (int i = 0; i < 150; i++) hv[i] = ($urandom_range(99) < 30);
            run_layer((r == 1) ? int'($urandom_range(30, 5)) : -1, NONE);
        end

        clear_hv();
        for (int i = 0; i < 150; i++) hv[i] = ($urandom_range(99) < 25);
        run_layer(-1, int'($urandom_range(40, 4)));

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
